// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares the single-port 8 KB video RAM between the text display adapter and
// the CPU bus, and holds the CPU-programmable cursor position register.
//
// The display owns the character-cell phases whose DISP_MASK bit is set while
// disp_active is high. Every other cycle, and every cycle during blanking, is
// a CPU slot.
//
// CPU handshake: the CPU raises cpu_req with cpu_we/cpu_address/cpu_wdata and
// holds it until it sees cpu_ack. The request is sampled (and its fields
// latched) only in IDLE. cpu_ack is a single-cycle pulse in DONE. cpu_rdata is
// valid in the ack cycle and held until the next read completes. A request
// still high in the cycle after the ack starts a new access.
//
// Ports:
//   clock, reset_n      posedge clock, synchronous active-low reset
//   disp_active         display is fetching (phase-based slot ownership)
//   disp_phase[2:0]     character-cell phase
//   disp_address[12:0]  display fetch address
//   disp_data[7:0]      RAM read data to the display (copy of mem_rdata)
//   mem_address[12:0]   RAM address (combinational mux)
//   mem_wdata[7:0]      RAM write data
//   mem_we              RAM write enable
//   mem_rdata[7:0]      registered RAM read data
//   cpu_req, cpu_we, cpu_address[12:0], cpu_wdata[7:0]  CPU request side
//   cpu_rdata[7:0], cpu_ack                             CPU response side
//   io_we, io_sel, io_wdata[7:0]   cursor register writes (sel 0 = low byte)
//   cursor[10:0]        cursor position to the display
//   fsm_state[1:0]      current arbiter FSM state (debug observation)

module vram_arbiter #(
  parameter logic [7:0] DISP_MASK = 8'b0000_1111
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        disp_active,
  input  logic [2:0]  disp_phase,
  input  logic [12:0] disp_address,
  output logic [7:0]  disp_data,
  output logic [12:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        io_we,
  input  logic        io_sel,
  input  logic [7:0]  io_wdata,
  output logic [10:0] cursor,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_RDATA = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic [12:0] lat_address;
  logic [7:0]  lat_wdata;
  logic        lat_we;
  logic [7:0]  staging;
  logic        slot_cpu;
  logic        cpu_drive;
  logic        grant_write;

  assign slot_cpu = !disp_active || !DISP_MASK[disp_phase];

  // The CPU owns the RAM port only while waiting and its slot is open.
  assign cpu_drive = (state == S_WAIT) && slot_cpu;

  // Gated by reset_n so a reset landing on the grant cycle cannot write RAM.
  assign grant_write = reset_n && cpu_drive && lat_we;

  always_comb begin
    mem_address = disp_address;
    mem_we      = 1'b0;
    mem_wdata   = 8'h00;
    if (cpu_drive) begin
      mem_address = lat_address;
    end
    if (grant_write) begin
      mem_we    = 1'b1;
      mem_wdata = lat_wdata;
    end
  end

  assign disp_data = mem_rdata;
  assign cpu_ack   = (state == S_DONE);
  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      lat_address <= 13'd0;
      lat_wdata   <= 8'h00;
      lat_we      <= 1'b0;
      cpu_rdata   <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            lat_address <= cpu_address;
            lat_wdata   <= cpu_wdata;
            lat_we      <= cpu_we;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (slot_cpu) begin
            state <= lat_we ? S_DONE : S_RDATA;
          end
        end
        S_RDATA: begin
          // Read data for the address presented last cycle; the current
          // slot owner does not matter here.
          cpu_rdata <= mem_rdata;
          state     <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Cursor: the low byte is staged so the full value updates in one cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      staging <= 8'h00;
      cursor  <= 11'd0;
    end else if (io_we) begin
      if (!io_sel) begin
        staging <= io_wdata;
      end else begin
        cursor <= {io_wdata[2:0], staging};
      end
    end
  end

endmodule
